sequential_divider_unit: RTL

Multi-cycle restoring shift-subtract divider for the MIPS DIV/DIVU path. It is the iterative counterpart of the single-cycle adder/subtractor. Each step is one trial subtraction, and the no-borrow carry-out decides the quotient bit. The block sits beside the ALU and delivers the quotient to LO and the remainder to HI through a start/busy/done handshake with the control unit.

---
 rtl/sequential_divider_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sequential_divider_unit.sv
// Multi-cycle restoring shift-subtract divider (DIV/DIVU) with start/busy/done handshake.
// Optional build macro DIV_EARLY_OUT_EN: finish immediately when |dividend| < |divisor|.
module sequential_divider_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startDiv,
    input  logic             signedDiv,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busyDiv,
    output logic             doneDiv,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divByZeroFlag
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] STEPS = CW'(WIDTH);
    localparam logic [CW-1:0] ONE   = CW'(1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] quo_shift;
    logic [WIDTH-1:0] dsr_mag;
    logic [CW-1:0]    step;
    logic             neg_quo;
    logic             neg_rem;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return -x;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? negate(x) : x;
    endfunction

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic             early;

    assign mag_a = magnitude(dividend, signedDiv);
    assign mag_b = magnitude(divisor, signedDiv);

    // P < |divisor| always holds, so the top bit of the WIDTH+1-bit difference is the borrow.
    assign shifted = {part_rem, quo_shift[WIDTH-1]};
    assign trial   = shifted - {1'b0, dsr_mag};
    assign borrow  = trial[WIDTH];

`ifdef DIV_EARLY_OUT_EN
    assign early = (divisor != '0) && (mag_a < mag_b);
`else
    assign early = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            busyDiv       <= 1'b0;
            doneDiv       <= 1'b0;
            divByZeroFlag <= 1'b0;
            quotient      <= '0;
            remainder     <= '0;
            part_rem      <= '0;
            quo_shift     <= '0;
            dsr_mag       <= '0;
            step          <= '0;
            neg_quo       <= 1'b0;
            neg_rem       <= 1'b0;
        end else begin
            doneDiv <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (startDiv) begin
                        divByZeroFlag <= 1'b0;
                        neg_quo       <= signedDiv & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_rem       <= signedDiv & dividend[WIDTH-1];
                        part_rem      <= '0;
                        quo_shift     <= mag_a;
                        dsr_mag       <= mag_b;
                        step          <= STEPS;
                        if (divisor == '0) begin
                            quotient      <= '1;
                            remainder     <= dividend;
                            divByZeroFlag <= 1'b1;
                            doneDiv       <= 1'b1;
                            state         <= DONE;
                        end else if (early) begin
                            quotient  <= '0;
                            remainder <= dividend;
                            doneDiv   <= 1'b1;
                            state     <= DONE;
                        end else begin
                            busyDiv <= 1'b1;
                            state   <= RUN;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    part_rem  <= borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                    quo_shift <= {quo_shift[WIDTH-2:0], ~borrow};
                    if (step == ONE) begin
                        state <= FIX;
                    end else begin
                        step <= step - ONE;
                    end
                end
                FIX: begin
                    // Remainder takes the dividend's sign; quotient negative when signs differ.
                    quotient  <= neg_quo ? negate(quo_shift) : quo_shift;
                    remainder <= neg_rem ? negate(part_rem) : part_rem;
                    busyDiv   <= 1'b0;
                    doneDiv   <= 1'b1;
                    state     <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
